// File: rtl/dadda_pkg.sv
// Shared definitions for the DADDA multiplier datapath: default sizes,
// accumulator width helper and the product type.
package dadda_pkg;

    localparam int unsigned BIT_DEF = 8;
    localparam int unsigned LEN_DEF = 4;

    typedef logic [2*BIT_DEF-2:0] prod_t;

    function automatic int unsigned acc_w(input int unsigned bit_w, input int unsigned len);
        return 2*bit_w - 1 + $clog2(len);
    endfunction

endpackage

// File: rtl/dadda_dot_acc.sv
// Dot-product accumulator: sums up to LEN unsigned products per group and
// presents each group sum on a registered valid/ready result interface.
module dadda_dot_acc
    import dadda_pkg::*;
#(
    parameter int unsigned BIT   = BIT_DEF,
    parameter int unsigned LEN   = LEN_DEF,
    parameter int unsigned ACC_W = acc_w(BIT, LEN)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*BIT-2:0]         in_prod,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic [$clog2(LEN):0]     out_count
);

    localparam int unsigned CW = $clog2(LEN);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CW:0]      count_q, count_d;
    logic             valid_q, valid_d;

    logic             closing;
    logic             accept;
    logic             release_res;
    logic [ACC_W-1:0] total;

    assign closing     = (cnt_q == CW'(LEN - 1)) || in_last;
    // Only a closing beat needs the result register, so only it can stall.
    assign in_ready    = !(closing && valid_q && !out_ready);
    assign accept      = in_valid && in_ready;
    assign release_res = valid_q && out_ready;
    assign total       = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(in_prod);

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        count_d = count_q;
        valid_d = valid_q;
        if (release_res) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (closing) begin
                sum_d   = total;
                count_d = (CW+1)'(cnt_q) + (CW+1)'(1);
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                acc_d = total;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_dadda_dot_acc.sv
// Directed self-checking bench for dadda_dot_acc (BIT=8, LEN=4, ACC_W=17).
module tb_dadda_dot_acc;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic [2:0]  out_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    dadda_dot_acc #(.BIT(8), .LEN(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one beat, confirm it will be accepted, and clock it in.
    task automatic beat(input logic [14:0] p, input logic last);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        #1;
        check("beat_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = '0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] sum, input logic [31:0] cnt);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(out_sum),   sum);
        check({tag, "_count"}, 32'(out_count), cnt);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum",   32'(out_sum),   32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        reset = 1'b0;
        tick();

        // Full group of four small products
        beat(15'd10, 1'b0);
        beat(15'd20, 1'b0);
        beat(15'd30, 1'b0);
        check("mid_group_novalid", 32'(out_valid), 32'd0);
        beat(15'd40, 1'b0);
        expect_result("g100", 32'd100, 32'd4);
        tick();
        check("g100_drop", 32'(out_valid), 32'd0);

        // Largest 7x8-bit product, four times
        repeat (4) beat(15'd32385, 1'b0);
        expect_result("gmax", 32'd129540, 32'd4);
        tick();

        // Early close, then a fresh group starting from zero
        beat(15'd5, 1'b0);
        beat(15'd7, 1'b1);
        expect_result("early", 32'd12, 32'd2);
        beat(15'd1, 1'b1);
        expect_result("after_early", 32'd1, 32'd1);
        tick();

        // Back-pressure: group A pending, group B stalls on its closing beat
        out_ready = 1'b0;
        repeat (4) beat(15'd1, 1'b0);
        expect_result("grpA", 32'd4, 32'd4);
        repeat (3) beat(15'd2, 1'b0);
        in_valid = 1'b1;
        in_prod  = 15'd2;
        #1;
        check("stall_ready", 32'(in_ready), 32'd0);
        tick();
        expect_result("grpA_hold", 32'd4, 32'd4);
        out_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_prod  = '0;
        expect_result("grpB", 32'd8, 32'd4);
        tick();
        check("grpB_drop", 32'(out_valid), 32'd0);

        // Single-beat groups every cycle
        beat(15'd3, 1'b1);
        expect_result("single3", 32'd3, 32'd1);
        beat(15'd9, 1'b1);
        expect_result("single9", 32'd9, 32'd1);
        beat(15'd0, 1'b1);
        expect_result("single0", 32'd0, 32'd1);
        tick();
        check("single_drop", 32'(out_valid), 32'd0);

        // Reset with a pending result and a partial group
        out_ready = 1'b0;
        beat(15'd6, 1'b1);
        beat(15'd1, 1'b0);
        beat(15'd1, 1'b0);
        expect_result("pend", 32'd6, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sum",   32'(out_sum),   32'd0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        beat(15'd1, 1'b0);
        beat(15'd2, 1'b0);
        beat(15'd3, 1'b0);
        beat(15'd4, 1'b0);
        expect_result("post_rst", 32'd10, 32'd4);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
